// File: rtl/stv_util_pkg.sv
// Shared types and helpers for the stream arbitration blocks.
//   stv_arb_state_e : arbiter lock state (idle / locked on a packet)
//   stv_idx_width   : index width for an N-entry select, never below 1 bit
package stv_util_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} stv_arb_state_e;

  function automatic int unsigned stv_idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stv_priority_arbiter.sv
// Combinational fixed-priority arbiter; the lowest-indexed request wins.
//   req : request vector
//   gnt : one-hot grant, all-zero when no request
module stv_priority_arbiter #(
  parameter int unsigned INPUTS = 4
) (
  input  logic [INPUTS-1:0] req,
  output logic [INPUTS-1:0] gnt
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt = req & (~req + INPUTS'(1));

endmodule

// File: rtl/stv_rr_stream_arbiter.sv
// N-to-1 valid/ready stream arbiter with round-robin fairness and optional
// packet locking, so multi-beat packets are never interleaved.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : per-stream valid
//   in_ready   : per-stream ready (grant qualified by out_ready)
//   in_data    : per-stream payload
//   in_last    : per-stream end-of-packet marker
//   out_valid  : arbitrated valid
//   out_ready  : downstream ready
//   out_data   : selected payload (0 when not valid)
//   out_last   : selected last (0 when not valid)
//   out_sel    : selected stream index (0 when not valid)
module stv_rr_stream_arbiter
  import stv_util_pkg::*;
#(
  parameter int unsigned INPUTS       = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter bit          LOCK_ON_LAST = 1'b1,
  localparam int unsigned IDX_W       = stv_idx_width(INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INPUTS-1:0]                in_valid,
  output logic [INPUTS-1:0]                in_ready,
  input  logic [INPUTS-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [INPUTS-1:0]                in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [IDX_W-1:0]                 out_sel
);

  stv_arb_state_e    state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  lock_q, lock_d;

  logic [INPUTS-1:0] mask;
  logic [INPUTS-1:0] lock_oh;
  logic [INPUTS-1:0] gnt_masked;
  logic [INPUTS-1:0] gnt_unmasked;
  logic [INPUTS-1:0] gnt;
  logic [IDX_W-1:0]  sel;
  logic              sel_last;
  logic              hs;

  // Requests strictly above the last winner get first pick; when none are
  // pending (including ptr = INPUTS-1) the unmasked arbiter wraps around.
  always_comb begin
    mask    = '0;
    lock_oh = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      mask[i]    = (IDX_W'(i) > ptr_q);
      lock_oh[i] = (IDX_W'(i) == lock_q);
    end
  end

  stv_priority_arbiter #(.INPUTS(INPUTS)) u_arb_masked (
    .req (in_valid & mask),
    .gnt (gnt_masked)
  );

  stv_priority_arbiter #(.INPUTS(INPUTS)) u_arb_unmasked (
    .req (in_valid),
    .gnt (gnt_unmasked)
  );

  always_comb begin
    if (state_q == ARB_LOCKED) begin
      gnt = lock_oh & in_valid;
    end else if (|gnt_masked) begin
      gnt = gnt_masked;
    end else begin
      gnt = gnt_unmasked;
    end
  end

  // One-hot to index, plus the payload mux driven by the same grant.
  always_comb begin
    sel      = '0;
    sel_last = 1'b0;
    out_data = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (gnt[i]) begin
        sel      = IDX_W'(i);
        sel_last = in_last[i];
        out_data = in_data[i];
      end
    end
    if (state_q == ARB_LOCKED) begin
      sel = lock_q;
    end
  end

  assign out_valid = |gnt;
  assign out_last  = sel_last;
  assign out_sel   = out_valid ? sel : '0;
  assign in_ready  = gnt & {INPUTS{out_ready}};
  assign hs        = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (hs) begin
      case (state_q)
        ARB_IDLE: begin
          if (sel_last || !LOCK_ON_LAST) begin
            ptr_d = sel;
          end else begin
            state_d = ARB_LOCKED;
            lock_d  = sel;
          end
        end
        ARB_LOCKED: begin
          if (sel_last) begin
            state_d = ARB_IDLE;
            ptr_d   = lock_q;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= IDX_W'(INPUTS - 1);
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

endmodule

// File: tb/tb_stv_rr_stream_arbiter.sv
module tb_stv_rr_stream_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [3:0][31:0] in_data;
  logic [3:0]       in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;
  logic [1:0]       out_sel;

  // Second instance without packet locking.
  logic [3:0]       v1;
  logic [3:0]       ir1;
  logic [3:0][31:0] d1;
  logic [3:0]       l1;
  logic             ov1;
  logic             or1;
  logic [31:0]      od1;
  logic             ol1;
  logic [1:0]       os1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stv_rr_stream_arbiter #(.INPUTS(4), .DATA_WIDTH(32), .LOCK_ON_LAST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel)
  );

  stv_rr_stream_arbiter #(.INPUTS(4), .DATA_WIDTH(32), .LOCK_ON_LAST(1'b0)) dut_nl (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(ir1), .in_data(d1), .in_last(l1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .out_last(ol1), .out_sel(os1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: last winner, lock flag, locked stream.
  int m_ptr = 3;
  int m_lock = 0;
  bit m_locked = 1'b0;
  bit ev;
  int ei;

  always @(posedge rst) begin
    m_ptr = 3; m_locked = 1'b0; m_lock = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      m_ptr = 3; m_locked = 1'b0; m_lock = 0;
    end else begin
      ev = 1'b0;
      ei = 0;
      if (m_locked) begin
        if (in_valid[m_lock]) begin ev = 1'b1; ei = m_lock; end
      end else begin
        // Search starting just after the last winner, wrapping around.
        for (int k = 1; k <= 4; k++) begin
          int j;
          j = (m_ptr + k) % 4;
          if (!ev && in_valid[j]) begin ev = 1'b1; ei = j; end
        end
      end
      chk("m_valid", 64'(out_valid), 64'(ev));
      chk("m_sel",   64'(out_sel),   ev ? 64'(ei) : 64'd0);
      chk("m_data",  64'(out_data),  ev ? 64'(in_data[ei]) : 64'd0);
      chk("m_last",  64'(out_last),  ev ? 64'(in_last[ei]) : 64'd0);
      chk("m_ready", 64'(in_ready),  (ev && out_ready) ? 64'(1 << ei) : 64'd0);
      if (ev && out_ready) begin
        if (m_locked) begin
          if (in_last[ei]) begin m_locked = 1'b0; m_ptr = ei; end
        end else if (in_last[ei]) begin
          m_ptr = ei;
        end else begin
          m_locked = 1'b1; m_lock = ei;
        end
      end
    end
  end

  logic [3:0] acc;

  initial begin
    rst = 1'b1;
    in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
    v1 = '0; d1 = '0; l1 = '0; or1 = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_sel",   64'(out_sel), 64'd0);
    chk("rst_data",  64'(out_data), 64'd0);
    in_valid = 4'b1111;
    #1;
    chk("rst_prio0", 64'(out_sel), 64'd0);
    chk("rst_hold_ready", 64'(in_ready), 64'd0);
    step();

    // Test 1: round-robin over four single-beat requesters
    rst = 1'b0;
    in_last = 4'b1111;
    for (int i = 0; i < 4; i++) in_data[i] = 32'h100 + 32'(i);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_sel", 64'(out_sel), 64'(k % 4));
      chk("t1_ready", 64'(in_ready), 64'(1 << (k % 4)));
      step();
    end

    // Test 2: three-beat packet on stream 1 is not interleaved
    in_valid = 4'b0111; in_last = 4'b0101;
    in_data[0] = 32'hA0; in_data[1] = 32'hB1; in_data[2] = 32'hC2;
    @(negedge clk);
    chk("t2_sel_b1", 64'(out_sel), 64'd1);
    chk("t2_data_b1", 64'(out_data), 64'hB1);
    step();
    in_data[1] = 32'hB2;
    @(negedge clk);
    chk("t2_sel_b2", 64'(out_sel), 64'd1);
    chk("t2_data_b2", 64'(out_data), 64'hB2);
    step();
    in_data[1] = 32'hB3; in_last = 4'b0111;
    @(negedge clk);
    chk("t2_sel_b3", 64'(out_sel), 64'd1);
    chk("t2_data_b3", 64'(out_data), 64'hB3);
    chk("t2_last_b3", 64'(out_last), 64'd1);
    step();
    in_valid = 4'b0101;
    @(negedge clk);
    chk("t2_sel_s2", 64'(out_sel), 64'd2);
    chk("t2_data_s2", 64'(out_data), 64'hC2);
    step();
    @(negedge clk);
    chk("t2_sel_s0", 64'(out_sel), 64'd0);
    step();

    // Test 3: backpressure freezes arbitration
    in_valid = 4'b0100; in_last = 4'b1111; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_valid", 64'(out_valid), 64'd1);
      chk("t3_sel", 64'(out_sel), 64'd2);
      chk("t3_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_hs_ready", 64'(in_ready), 64'b0100);
    step();
    in_valid = 4'b1111;
    @(negedge clk);
    chk("t3_ptr2_next", 64'(out_sel), 64'd3);
    step();

    // Test 4: locked stream drops valid; others stay ignored
    in_valid = 4'b1000; in_last = 4'b0000; in_data[3] = 32'hD3;
    @(negedge clk);
    chk("t4_sel3", 64'(out_sel), 64'd3);
    step();
    in_valid = 4'b0001; in_last = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_gap_valid", 64'(out_valid), 64'd0);
      chk("t4_gap_ready", 64'(in_ready), 64'd0);
      step();
    end
    in_valid = 4'b1001; in_last = 4'b1001; in_data[3] = 32'hD4;
    @(negedge clk);
    chk("t4_resume_sel", 64'(out_sel), 64'd3);
    chk("t4_resume_last", 64'(out_last), 64'd1);
    chk("t4_resume_data", 64'(out_data), 64'hD4);
    step();
    in_valid = 4'b0001;
    @(negedge clk);
    chk("t4_then_s0", 64'(out_sel), 64'd0);
    step();

    // Test 5: asynchronous reset while locked on stream 2
    in_valid = 4'b0100; in_last = 4'b0000;
    @(negedge clk);
    chk("t5_sel2", 64'(out_sel), 64'd2);
    step();
    in_valid = 4'b0110; in_last = 4'b0110;
    chk("t5_locked", 64'(out_sel), 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_sel", 64'(out_sel), 64'd1);
    chk("t5_rst_ready", 64'(in_ready), 64'b0010);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_after_sel", 64'(out_sel), 64'd1);
    step();
    @(negedge clk);
    chk("t5_next_sel", 64'(out_sel), 64'd2);
    step();

    // Random traffic against the model
    in_valid = '0; in_last = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      step();
      for (int i = 0; i < 4; i++) begin
        if (acc[i] || !in_valid[i]) begin
          if ($urandom_range(0, 9) < 6) begin
            in_valid[i] = 1'b1;
            in_data[i]  = $urandom;
            in_last[i]  = ($urandom_range(0, 2) == 0);
          end else begin
            in_valid[i] = 1'b0;
          end
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = '0;

    // Test 6: no locking, two-beat packets interleave
    or1 = 1'b1;
    v1 = 4'b0011; l1 = 4'b0000; d1[0] = 32'h0A; d1[1] = 32'h1A;
    @(negedge clk);
    chk("t6_c1_sel", 64'(os1), 64'd0);
    chk("t6_c1_data", 64'(od1), 64'h0A);
    chk("t6_c1_last", 64'(ol1), 64'd0);
    step();
    d1[0] = 32'h0B; l1 = 4'b0001;
    @(negedge clk);
    chk("t6_c2_sel", 64'(os1), 64'd1);
    chk("t6_c2_data", 64'(od1), 64'h1A);
    chk("t6_c2_last", 64'(ol1), 64'd0);
    step();
    d1[1] = 32'h1B; l1 = 4'b0011;
    @(negedge clk);
    chk("t6_c3_sel", 64'(os1), 64'd0);
    chk("t6_c3_data", 64'(od1), 64'h0B);
    chk("t6_c3_last", 64'(ol1), 64'd1);
    step();
    v1 = 4'b0010;
    @(negedge clk);
    chk("t6_c4_sel", 64'(os1), 64'd1);
    chk("t6_c4_data", 64'(od1), 64'h1B);
    chk("t6_c4_last", 64'(ol1), 64'd1);
    step();
    v1 = '0;
    @(negedge clk);
    chk("t6_idle_valid", 64'(ov1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
